mux_2_1_arbiter: RTL and testbench
==================================

# mux_2_1_arbiter

Round-robin arbiter and output stage that shares one WIDTH-bit 2:1 select path between two requesters. It decides which requester owns the path, drives the select, and acknowledges each accepted beat. It registers the selected data into a valid/ready output stage. It sits in front of any single-consumer sink that two producers must share, and it is the controlling block for the existing `mux_2_1` bit-slice.

## Interface
Parameters:
- `WIDTH`, default 8: data width per requester.
- `HOLD_MAX`, default 4: maximum consecutive accepted beats for one owner while the other requester is waiting. Legal range is 1..255.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 2: `req[n]` = requester n has a beat on `din_n`. Held until granted.
- `din0`, input, WIDTH: requester 0 data.
- `din1`, input, WIDTH: requester 1 data.
- `gnt`, output, 2: `gnt[n]` = `din_n` is captured at this clock edge. Combinational, one-hot or zero.
- `sel`, output, 1: current select. 0 = requester 0, 1 = requester 1. Registered.
- `dout`, output, WIDTH: registered output data.
- `dout_valid`, output, 1: `dout` holds an unconsumed beat.
- `dout_ready`, input, 1: sink accepts `dout` this cycle.

## Operation
- FSM states: IDLE, OWN0, OWN1. `sel` = 1 in OWN1 and 0 otherwise.
- `accept` = `!dout_valid || dout_ready`.
- `gnt[n]` = (state==OWNn) && `req[n]` && `accept`. No grant is issued in IDLE.
- On `gnt[n]`: `dout` <= `din_n` through the select path, and `dout_valid` <= 1.
- Otherwise, if `dout_ready`: `dout_valid` <= 0.
- `last` register holds the last owner. Reset value is 1, so requester 0 wins the first tie.
- `cnt` is an 8-bit count of consecutive granted beats for the current owner. It is cleared on any ownership change.
- IDLE transitions:
  - `req`==2'b11 -> OWN(!`last`).
  - `req`==2'b01 -> OWN0.
  - `req`==2'b10 -> OWN1.
  - 0 -> stay in IDLE.
- OWNn transitions, evaluated every cycle with m = 1-n:
  - `!req[n]` && `req[m]` -> OWNm.
  - `!req[n]` && `!req[m]` -> IDLE.
  - `gnt[n]` && `req[m]` && `cnt`==HOLD_MAX-1 -> OWNm. This is the fairness switch.
  - Otherwise stay in OWNn. `cnt` increments on `gnt[n]` and saturates when the other requester is idle.
- Entering OWNn sets `last` <= n.
- OWNn -> OWNm is direct, with no IDLE bubble.
- Backpressure: while `dout_valid && !dout_ready`, no grants are issued. State and `cnt` hold, except for transitions caused by `req` drops.
- A requester that deasserts `req` without a grant loses its beat. No error is flagged.

## Timing
- Reset values: state IDLE, `sel` 0, `gnt` 0, `dout` 0, `dout_valid` 0, `last` 1, `cnt` 0.
- Latency: `req[n]` is sampled in IDLE at edge k. The state is OWNn after k. `gnt[n]` is high in cycle k+1. `dout`/`dout_valid` are valid after edge k+1.
- Sustained throughput is 1 beat/cycle with `dout_ready` held at 1.
- An ownership switch costs 0 cycles. The first beat of the new owner is granted in the cycle after the last beat of the old owner.
- Reset mid-transfer: the held beat is discarded, `dout_valid` drops on that edge, and `gnt` is 0 during the reset cycle.
- `sel` changes only on clock edges. `gnt` depends combinationally on `req`, `dout_valid` and `dout_ready`.

## Structure
- Package `mux_arb_pkg` holds the state encoding localparams: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
- Sub-module: WIDTH generate-instances of the existing `mux_2_1` (Y, I[1:0], S). Each instance has I = {`din1[i]`, `din0[i]`} and S = `sel`. Its output feeds the `dout` register.
- The FSM, counter and output register live in one always block set within `mux_2_1_arbiter`.

## Test plan
- Reset then single requester: `req`=01, `din0`=8'hA5, `dout_ready`=1. Expect `gnt`=01 in the cycle after `req` is sampled, `dout`=8'hA5 with `dout_valid`=1 one edge later, and `sel`=0.
- Tie after reset: `req`=11, `din0`=8'h11, `din1`=8'h22, HOLD_MAX=4, sink always ready. Expect beats 11,11,11,11,22,22,22,22,11…, `sel` toggling every 4 beats, and no idle cycle between owners.
- Backpressure: stream from requester 1 with `dout_ready`=0 for 3 cycles. Expect `dout` and `dout_valid`=1 held stable, `gnt`=00 for those cycles, and the stream resuming with no beat lost or duplicated.
- Owner drop: OWN0 with `req` falling to 00. Expect IDLE next edge and `gnt`=00. A later `req`=10 must give OWN1 with one cycle of grant latency.
- Reset mid-stream: assert `rst` for 1 cycle while `dout_valid`=1 in OWN1. Expect all outputs at reset values after that edge and `last`=1, so a following `req`=11 grants requester 0 first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - state encoding and helpers shared by the two-requester arbiter
package mux_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t OWN0 = 2'd1;
   localparam state_t OWN1 = 2'd2;

   localparam int CNT_W = 8;

   // Ownership state for requester n
   function automatic state_t own_state(input logic n);
      return n ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/mux_2_1.sv
// rtl/mux_2_1.sv - single-bit 2:1 select slice
module mux_2_1 (
   output logic       Y,
   input  logic [1:0] I,
   input  logic       S
);

   assign Y = S ? I[1] : I[0];

endmodule

// File: rtl/mux_2_1_arbiter.sv
// rtl/mux_2_1_arbiter.sv - round-robin owner FSM driving a shared 2:1 select path into a valid/ready output register
module mux_2_1_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   output logic [1:0]       gnt,
   output logic             sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready
);

   // Beat count at which a waiting requester takes over on the next grant
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);

   state_t           state;
   state_t           state_next;
   logic             last;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic [WIDTH-1:0] mux_y;

   // One bit-slice per data bit; every slice shares the registered select
   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      mux_2_1 u_mux (
         .Y (mux_y[i]),
         .I ({din1[i], din0[i]}),
         .S (sel)
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state: req drops move ownership at once, fairness switch only on a granted beat
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            case (req)
               2'b11:   state_next = own_state(!last);
               2'b01:   state_next = OWN0;
               2'b10:   state_next = OWN1;
               default: state_next = IDLE;
            endcase
         end
         OWN0: begin
            if (!req[0])                                    state_next = req[1] ? OWN1 : IDLE;
            else if (gnt[0] && req[1] && (cnt >= HOLD_LIM)) state_next = OWN1;
         end
         OWN1: begin
            if (!req[1])                                    state_next = req[0] ? OWN0 : IDLE;
            else if (gnt[1] && req[0] && (cnt >= HOLD_LIM)) state_next = OWN0;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: select follows the owner, grants only when the output register can take a beat
   always_comb begin
      accept = !dout_valid || dout_ready;
      sel    = (state == OWN1);
      gnt    = 2'b00;
      if (!rst) begin
         gnt[0] = (state == OWN0) && req[0] && accept;
         gnt[1] = (state == OWN1) && req[1] && accept;
      end
   end

   // Last owner and consecutive-beat counter; counter parks at the limit while nobody waits
   always_ff @(posedge clk) begin
      if (rst) begin
         last <= 1'b1;
         cnt  <= '0;
      end else begin
         if (state_next != state) begin
            cnt <= '0;
            if (state_next != IDLE) last <= (state_next == OWN1);
         end else if ((|gnt) && (cnt < HOLD_LIM)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Output register: capture on grant, release when the sink takes the beat
   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (|gnt) begin
         dout       <= mux_y;
         dout_valid <= 1'b1;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// tb/tb_mux_2_1_arbiter.sv - directed vector bench for mux_2_1_arbiter
module tb_mux_2_1_arbiter;

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       rdy;
      logic [1:0] e_gnt;
      logic       e_sel;
      logic       e_valid;
      logic [7:0] e_dout;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [7:0] din0;
   logic [7:0] din1;
   logic [1:0] gnt;
   logic       sel;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mux_2_1_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din0       (din0),
      .din1       (din1),
      .gnt        (gnt),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] q, input logic [7:0] a, input logic [7:0] b,
                      input logic y, input logic [1:0] g, input logic s, input logic v, input logic [7:0] o);
      vec_t t;
      t.rst = r; t.req = q; t.d0 = a; t.d1 = b; t.rdy = y;
      t.e_gnt = g; t.e_sel = s; t.e_valid = v; t.e_dout = o;
      vecs.push_back(t);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int waited;

      //    rst req    d0     d1     rdy gnt    sel   vld   dout
      add(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1'b0, 1'b0, 8'h00);
      // single requester 0
      add(0, 2'b01, 8'hA5, 8'h00, 1, 2'b00, 1'b0, 1'b0, 8'h00);
      add(0, 2'b01, 8'hA5, 8'h00, 1, 2'b01, 1'b0, 1'b0, 8'h00);
      add(0, 2'b00, 8'hA5, 8'h00, 1, 2'b00, 1'b0, 1'b1, 8'hA5);
      add(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1'b0, 1'b0, 8'hA5);
      // later request from 1 after owner drop
      add(0, 2'b10, 8'h00, 8'h3C, 1, 2'b00, 1'b0, 1'b0, 8'hA5);
      add(0, 2'b10, 8'h00, 8'h3C, 1, 2'b10, 1'b1, 1'b0, 8'hA5);
      add(0, 2'b00, 8'h00, 8'h3C, 1, 2'b00, 1'b1, 1'b1, 8'h3C);
      // tie: last=1 so requester 0 first, 4 beats each
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b00, 1'b0, 1'b0, 8'h3C);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b0, 8'h3C);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b1, 8'h11);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b1, 8'h11);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b1, 8'h11);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b1, 1'b1, 8'h11);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b1, 1'b1, 8'h22);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b1, 1'b1, 8'h22);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b10, 1'b1, 1'b1, 8'h22);
      add(0, 2'b11, 8'h11, 8'h22, 1, 2'b01, 1'b0, 1'b1, 8'h22);
      // requester 0 drops, direct handover to 1
      add(0, 2'b10, 8'h11, 8'h22, 1, 2'b00, 1'b0, 1'b1, 8'h11);
      // requester 1 stream with 3 cycles of backpressure
      add(0, 2'b10, 8'h00, 8'h40, 1, 2'b10, 1'b1, 1'b0, 8'h11);
      add(0, 2'b10, 8'h00, 8'h41, 0, 2'b00, 1'b1, 1'b1, 8'h40);
      add(0, 2'b10, 8'h00, 8'h41, 0, 2'b00, 1'b1, 1'b1, 8'h40);
      add(0, 2'b10, 8'h00, 8'h41, 0, 2'b00, 1'b1, 1'b1, 8'h40);
      add(0, 2'b10, 8'h00, 8'h41, 1, 2'b10, 1'b1, 1'b1, 8'h40);
      add(0, 2'b10, 8'h00, 8'h42, 1, 2'b10, 1'b1, 1'b1, 8'h41);
      add(0, 2'b10, 8'h00, 8'h43, 1, 2'b10, 1'b1, 1'b1, 8'h42);
      // reset mid-stream in OWN1 with a held beat
      add(1, 2'b10, 8'h00, 8'h44, 1, 2'b00, 1'b1, 1'b1, 8'h43);
      add(0, 2'b11, 8'h55, 8'h66, 1, 2'b00, 1'b0, 1'b0, 8'h00);
      add(0, 2'b11, 8'h55, 8'h66, 1, 2'b01, 1'b0, 1'b0, 8'h00);
      add(0, 2'b00, 8'h55, 8'h66, 1, 2'b00, 1'b0, 1'b1, 8'h55);

      rst = 1'b1; req = 2'b00; din0 = 8'h00; din1 = 8'h00; dout_ready = 1'b1;
      tick();

      foreach (vecs[i]) begin
         rst = vecs[i].rst; req = vecs[i].req; din0 = vecs[i].d0; din1 = vecs[i].d1;
         dout_ready = vecs[i].rdy;
         #1;
         chk("gnt",        i, {6'd0, gnt},        {6'd0, vecs[i].e_gnt});
         chk("sel",        i, {7'd0, sel},        {7'd0, vecs[i].e_sel});
         chk("dout_valid", i, {7'd0, dout_valid}, {7'd0, vecs[i].e_valid});
         chk("dout",       i, dout,               vecs[i].e_dout);
         tick();
      end

      // long solo stream from 0, then 1 joins: counter is parked so the next beat hands over
      rst = 1'b1; req = 2'b00; dout_ready = 1'b1;
      tick();
      rst = 1'b0; req = 2'b01; din0 = 8'h77;
      tick();
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("solo_gnt", k, {6'd0, gnt}, 8'h01);
         tick();
      end
      req = 2'b11; din1 = 8'h88;
      #1;
      chk("fair_last_gnt0", 0, {6'd0, gnt}, 8'h01);
      tick();
      waited = 0;
      while (gnt !== 2'b10 && waited < 8) begin
         tick();
         waited++;
      end
      chk("fair_wait", 0, 8'(waited), 8'd0);
      chk("fair_sel", 0, {7'd0, sel}, 8'h01);
      chk("fair_dout", 0, dout, 8'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
